ora_compare: RTL

- Output Response Analyser stage directly upstream of the BIST controller; it produces the ORA_RES pulse that the controller consumes.
- Compares the faulted CUT response against the golden-model response, pattern by pattern. The golden path is delayed by CUT_LATENCY so both responses line up.
- Raises a one-cycle ORA_RES pulse on the first mismatch after each TPG reset. The controller uses this pulse to count the error, restart the TPG and advance the fault list.
- Also reports the index of the failing pattern and a drain-complete pulse after the TPG finishes.

---
 rtl/ora_compare.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ora_compare.sv
// ora_compare: output response analyser comparing CUT responses against latency-aligned golden responses.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   TPG_RESET  synchronous restart from the BIST controller (clears pipeline, counter, FSM)
//   PAT_VALID  TPG issued a pattern this cycle
//   TPG_END    last pattern issued this cycle (qualified by PAT_VALID)
//   GOLD       golden-model response, valid with PAT_VALID
//   CUT        CUT response, valid CUT_LATENCY cycles after PAT_VALID
//   ORA_RES    registered one-cycle pulse on the first mismatch of an epoch
//   FAIL_IDX   index of the mismatching pattern, held until the next capture
//   MISMATCH   GOLD ^ CUT of the mismatching pattern, held
//   DONE       one-cycle pulse once the last pattern compared clean
//   SIGNATURE  MISR signature when ORA_MISR_EN is defined, otherwise 0
//
// Optional feature: define ORA_MISR_EN to build the Galois MISR behind SIGNATURE.
module ora_compare #(
    parameter int WIDTH       = 8,
    parameter int CUT_LATENCY = 1,
    parameter int CNT_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                TPG_RESET,
    input  logic                PAT_VALID,
    input  logic                TPG_END,
    input  logic [WIDTH-1:0]    GOLD,
    input  logic [WIDTH-1:0]    CUT,
    output logic                ORA_RES,
    output logic [CNT_BITS-1:0] FAIL_IDX,
    output logic [WIDTH-1:0]    MISMATCH,
    output logic                DONE,
    output logic [WIDTH-1:0]    SIGNATURE
);

    localparam logic [1:0] S_COMPARE = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_IDLE    = 2'd3;

    logic             av;
    logic             ae;
    logic [WIDTH-1:0] ag;

    generate
        if (CUT_LATENCY == 0) begin : g_direct
            assign av = PAT_VALID;
            assign ae = TPG_END;
            assign ag = GOLD;
        end else begin : g_dly
            logic [CUT_LATENCY-1:0] v_q;
            logic [CUT_LATENCY-1:0] e_q;
            logic [WIDTH-1:0]       g_q [CUT_LATENCY];
            always_ff @(posedge clk) begin
                if (rst || TPG_RESET) begin
                    v_q <= '0;
                    e_q <= '0;
                    for (int i = 0; i < CUT_LATENCY; i++) g_q[i] <= '0;
                end else begin
                    v_q[0] <= PAT_VALID;
                    e_q[0] <= TPG_END;
                    g_q[0] <= GOLD;
                    for (int i = 1; i < CUT_LATENCY; i++) begin
                        v_q[i] <= v_q[i-1];
                        e_q[i] <= e_q[i-1];
                        g_q[i] <= g_q[i-1];
                    end
                end
            end
            assign av = v_q[CUT_LATENCY-1];
            assign ae = e_q[CUT_LATENCY-1];
            assign ag = g_q[CUT_LATENCY-1];
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0]    mm_q, mm_d;
    logic                ora_q, ora_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    diff;
    logic                cmp;

    assign diff = ag ^ CUT;
    assign cmp  = state_q == S_COMPARE;

    always_comb begin
        state_d = state_q;
        fidx_d  = fidx_q;
        mm_d    = mm_q;
        ora_d   = 1'b0;
        done_d  = 1'b0;
        // Counter saturates so a runaway TPG never aliases back to index 0.
        cnt_d   = (av && (cmp || state_q == S_DRAIN) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        if (cmp && av && diff != '0) begin
            ora_d   = 1'b1;
            fidx_d  = cnt_q;
            mm_d    = diff;
            state_d = S_HOLD;
        end else if (cmp && av && ae) begin
            state_d = S_DRAIN;
        end
        if (state_q == S_DRAIN) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COMPARE;
            cnt_q   <= '0;
            fidx_q  <= '0;
            mm_q    <= '0;
            ora_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (TPG_RESET) begin
            // Capture registers survive a restart so the controller can still read them.
            state_q <= S_COMPARE;
            cnt_q   <= '0;
            ora_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fidx_q  <= fidx_d;
            mm_q    <= mm_d;
            ora_q   <= ora_d;
            done_q  <= done_d;
        end
    end

    assign ORA_RES  = ora_q;
    assign DONE     = done_q;
    assign FAIL_IDX = fidx_q;
    assign MISMATCH = mm_q;

`ifdef ORA_MISR_EN
    // Galois feedback taps: x^6+x^5+x^4+1 below the x^8 term, else just x^0.
    localparam logic [WIDTH-1:0] POLY = (WIDTH == 8) ? WIDTH'(8'h71) : WIDTH'(1);
    logic [WIDTH-1:0] sig_q, sig_d;
    assign sig_d = (av && cmp) ? ((sig_q << 1) ^ (sig_q[WIDTH-1] ? POLY : '0) ^ CUT) : sig_q;
    always_ff @(posedge clk) begin
        if (rst || TPG_RESET) sig_q <= '0;
        else sig_q <= sig_d;
    end
    assign SIGNATURE = sig_q;
`else
    assign SIGNATURE = '0;
`endif

endmodule
